// File: rtl/axi_rd_burst_gen.sv
// AXI4 read-burst master for memory bring-up: issues a programmable series
// of read bursts, folds returned data into a checksum, counts beats and
// flags RRESP / RLAST protocol errors.
module axi_rd_burst_gen #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [7:0]        cfg_len,
  input  logic [2:0]        cfg_size,
  input  logic [1:0]        cfg_burst,
  input  logic [CNT_W-1:0]  num_bursts,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [CNT_W-1:0]  beats_rcvd,
  output logic              err_resp,
  output logic              err_last,
  output logic              err_cfg,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] stride_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [7:0]        beat_idx_q;

  logic cfg_bad;
  logic beat;
  logic idx_last;
  logic burst_end;

  // Decode config legality and the per-beat burst-termination conditions
  always_comb begin
    cfg_bad   = (cfg_burst == 2'd3) ||
                ((cfg_burst == 2'd2) &&
                 !((cfg_len == 8'd1) || (cfg_len == 8'd3) ||
                   (cfg_len == 8'd7) || (cfg_len == 8'd15)));
    beat      = (state == DATA) && m_rvalid;
    idx_last  = (beat_idx_q == m_arlen);
    burst_end = beat && (idx_last || m_rlast);
  end

  // Next-state logic; m_rready is a pure decode of the registered state
  always_comb begin
    state_nxt = state;
    m_rready  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_bad || (num_bursts == '0)) state_nxt = DONE;
          else                               state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (m_arready) state_nxt = DATA;
      end
      DATA: begin
        m_rready = 1'b1;
        if (burst_end) begin
          if (remaining_q == CNT_ONE) state_nxt = DONE;
          else                        state_nxt = ADDR;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus registered status/handshake outputs derived from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      m_arvalid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      m_arvalid <= (state_nxt == ADDR);
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
    end
  end

  // Run configuration, address walk, and result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      m_araddr    <= '0;
      m_arlen     <= '0;
      m_arsize    <= '0;
      m_arburst   <= '0;
      stride_q    <= '0;
      remaining_q <= '0;
      beat_idx_q  <= '0;
      checksum    <= '0;
      beats_rcvd  <= '0;
      err_resp    <= 1'b0;
      err_last    <= 1'b0;
      err_cfg     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_araddr    <= base_addr;
            m_arlen     <= cfg_len;
            m_arsize    <= cfg_size;
            m_arburst   <= cfg_burst;
            stride_q    <= stride;
            remaining_q <= num_bursts;
            beat_idx_q  <= '0;
            checksum    <= '0;
            beats_rcvd  <= '0;
            err_resp    <= 1'b0;
            err_last    <= 1'b0;
            err_cfg     <= cfg_bad;
          end
        end
        ADDR: begin
          if (m_arready) beat_idx_q <= '0;
        end
        DATA: begin
          if (beat) begin
            checksum   <= checksum + m_rdata;
            beat_idx_q <= beat_idx_q + 8'd1;
            if (beats_rcvd != CNT_MAX) beats_rcvd <= beats_rcvd + CNT_ONE;
            if (m_rresp != 2'd0) err_resp <= 1'b1;
            if (m_rlast != idx_last) err_last <= 1'b1;
            if (burst_end) begin
              remaining_q <= remaining_q - CNT_ONE;
              m_araddr    <= m_araddr + stride_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_burst_gen.sv
// Directed bench for axi_rd_burst_gen: a behavioural AXI read slave returns
// word = address; expected AR addresses sit in a scoreboard queue.
module tb_axi_rd_burst_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] stride = '0;
  logic [7:0]  cfg_len = '0;
  logic [2:0]  cfg_size = '0;
  logic [1:0]  cfg_burst = '0;
  logic [15:0] num_bursts = '0;
  logic        busy, done, err_resp, err_last, err_cfg;
  logic [31:0] checksum;
  logic [15:0] beats_rcvd;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic        m_rlast = 1'b0;
  logic        m_rvalid = 1'b0;
  logic        m_rready;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_addr_q[$];
  logic [7:0]  exp_len;
  logic [2:0]  exp_size;
  logic [1:0]  exp_burst;

  int ar_hold = 0;
  bit r_gaps = 1'b0;
  int rlast_mode = 0;
  bit resp_err = 1'b0;
  int ar_count = 0;
  int done_count = 0;

  logic [31:0] bq_addr[$];
  logic [7:0]  bq_len[$];
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  int r_beat = 0;
  int r_n = 0;
  bit r_active = 1'b0;
  bit r_acc = 1'b0;
  int ar_wait = 0;
  int sb = 0;

  axi_rd_burst_gen #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
    .cfg_len(cfg_len), .cfg_size(cfg_size), .cfg_burst(cfg_burst),
    .num_bursts(num_bursts), .busy(busy), .done(done), .checksum(checksum),
    .beats_rcvd(beats_rcvd), .err_resp(err_resp), .err_last(err_last),
    .err_cfg(err_cfg), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sumBursts(input logic [31:0] base, input logic [31:0] strd,
                                            input int beats, input int n);
    logic [31:0] s;
    s = '0;
    for (int b = 0; b < n; b++)
      for (int i = 0; i < beats; i++)
        s = s + base + strd * 32'(b) + 32'(4 * i);
    return s;
  endfunction

  // Count done pulses away from the active edge
  always @(negedge clk) begin
    if (done) done_count++;
  end

  // Behavioural read slave: handshakes are predicted at the negedge for the next posedge
  always @(negedge clk) begin
    if (rst) begin
      m_arready = 1'b0;
      m_rvalid  = 1'b0;
      m_rlast   = 1'b0;
      m_rresp   = 2'd0;
      bq_addr.delete();
      bq_len.delete();
      r_active  = 1'b0;
      r_acc     = 1'b0;
      ar_wait   = 0;
    end else begin
      if (r_acc) begin
        r_beat++;
        if (r_beat == r_n) begin
          r_active = 1'b0;
          sb++;
        end
      end
      if (!r_active && bq_addr.size() > 0) begin
        r_addr   = bq_addr.pop_front();
        r_len    = bq_len.pop_front();
        r_beat   = 0;
        r_n      = (rlast_mode == 1) ? 3 : int'(r_len) + 1;
        r_active = 1'b1;
      end
      if (r_active) begin
        m_rvalid = r_gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_rdata  = r_addr + 32'(4 * r_beat);
        if (rlast_mode == 0)      m_rlast = (r_beat == int'(r_len));
        else if (rlast_mode == 1) m_rlast = (r_beat == 2);
        else                      m_rlast = 1'b0;
        m_rresp  = (resp_err && sb == 0 && r_beat == 1) ? 2'd2 : 2'd0;
      end else begin
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rresp  = 2'd0;
      end
      r_acc = m_rvalid && m_rready;

      if (m_arvalid) begin
        if (ar_wait < ar_hold) begin
          m_arready = 1'b0;
          ar_wait++;
          if (exp_addr_q.size() > 0) checkOutput("ar_stable_addr", 64'(m_araddr), 64'(exp_addr_q[0]));
          checkOutput("ar_stable_len", 64'(m_arlen), 64'(exp_len));
        end else begin
          m_arready = 1'b1;
        end
      end else begin
        m_arready = 1'b0;
      end
      if (m_arvalid && m_arready) begin
        ar_wait = 0;
        ar_count++;
        if (exp_addr_q.size() == 0) checkOutput("ar_unexpected", 64'(1), 64'(0));
        else checkOutput("araddr", 64'(m_araddr), 64'(exp_addr_q.pop_front()));
        checkOutput("arlen", 64'(m_arlen), 64'(exp_len));
        checkOutput("arsize", 64'(m_arsize), 64'(exp_size));
        checkOutput("arburst", 64'(m_arburst), 64'(exp_burst));
        bq_addr.push_back(m_araddr);
        bq_len.push_back(m_arlen);
      end
    end
  end

  // Drive one run request and push the AR addresses it must produce
  task automatic applyStimulus(input logic [31:0] base, input logic [31:0] strd, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic [15:0] n,
                               input bit legal);
    exp_len   = len;
    exp_size  = size;
    exp_burst = burst;
    sb        = 0;
    if (legal)
      for (int b = 0; b < int'(n); b++) exp_addr_q.push_back(base + strd * 32'(b));
    @(posedge clk); #1;
    base_addr  = base;
    stride     = strd;
    cfg_len    = len;
    cfg_size   = size;
    cfg_burst  = burst;
    num_bursts = n;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    if (!done) checkOutput("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic checkResults(input string tag, input logic [31:0] sum, input logic [15:0] beats,
                              input bit er, input bit el, input bit ec);
    checkOutput({tag, "_checksum"}, 64'(checksum), 64'(sum));
    checkOutput({tag, "_beats"}, 64'(beats_rcvd), 64'(beats));
    checkOutput({tag, "_err_resp"}, 64'(err_resp), 64'(er));
    checkOutput({tag, "_err_last"}, 64'(err_last), 64'(el));
    checkOutput({tag, "_err_cfg"}, 64'(err_cfg), 64'(ec));
  endtask

  task automatic checkDoneDrop(input string tag, input int dc0, input int ac0, input int n_ar);
    @(posedge clk); #1;
    checkOutput({tag, "_done_low"}, 64'(done), 64'(0));
    checkOutput({tag, "_busy_low"}, 64'(busy), 64'(0));
    checkOutput({tag, "_done_pulses"}, 64'(done_count - dc0), 64'(1));
    checkOutput({tag, "_ar_count"}, 64'(ar_count - ac0), 64'(n_ar));
    checkOutput({tag, "_sb_empty"}, 64'(exp_addr_q.size()), 64'(0));
  endtask

  initial begin
    int dc0;
    int ac0;
    int i;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_arvalid", 64'(m_arvalid), 64'(0));
    checkOutput("rst_rready", 64'(m_rready), 64'(0));
    checkOutput("rst_araddr", 64'(m_araddr), 64'(0));
    checkResults("rst", 32'h0, 16'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    $display("[TB] basic INCR sweep");
    dc0 = done_count; ac0 = ar_count;
    applyStimulus(32'h8000_0000, 32'h10, 8'd3, 3'd2, 2'd1, 16'd4, 1'b1);
    checkOutput("basic_arvalid_rise", 64'(m_arvalid), 64'(1));
    checkOutput("basic_busy", 64'(busy), 64'(1));
    waitDone(200);
    checkResults("basic", sumBursts(32'h8000_0000, 32'h10, 4, 4), 16'd16, 1'b0, 1'b0, 1'b0);
    checkDoneDrop("basic", dc0, ac0, 4);

    $display("[TB] backpressure");
    ar_hold = 5; r_gaps = 1'b1;
    dc0 = done_count; ac0 = ar_count;
    applyStimulus(32'h8000_0000, 32'h10, 8'd3, 3'd2, 2'd1, 16'd4, 1'b1);
    waitDone(500);
    checkResults("bp", sumBursts(32'h8000_0000, 32'h10, 4, 4), 16'd16, 1'b0, 1'b0, 1'b0);
    checkDoneDrop("bp", dc0, ac0, 4);
    ar_hold = 0; r_gaps = 1'b0;

    $display("[TB] early rlast");
    rlast_mode = 1;
    dc0 = done_count; ac0 = ar_count;
    applyStimulus(32'h0000_1000, 32'h100, 8'd3, 3'd2, 2'd1, 16'd2, 1'b1);
    waitDone(200);
    checkResults("early", sumBursts(32'h0000_1000, 32'h100, 3, 2), 16'd6, 1'b0, 1'b1, 1'b0);
    checkDoneDrop("early", dc0, ac0, 2);

    $display("[TB] missing rlast");
    rlast_mode = 2;
    dc0 = done_count; ac0 = ar_count;
    applyStimulus(32'h0000_2000, 32'h100, 8'd3, 3'd2, 2'd1, 16'd1, 1'b1);
    waitDone(200);
    checkResults("omit", sumBursts(32'h0000_2000, 32'h100, 4, 1), 16'd4, 1'b0, 1'b1, 1'b0);
    checkDoneDrop("omit", dc0, ac0, 1);
    rlast_mode = 0;

    $display("[TB] bad config wrap len 5");
    dc0 = done_count; ac0 = ar_count;
    applyStimulus(32'h0000_3000, 32'h10, 8'd5, 3'd2, 2'd2, 16'd3, 1'b0);
    checkOutput("badwrap_done_now", 64'(done), 64'(1));
    checkOutput("badwrap_arvalid", 64'(m_arvalid), 64'(0));
    checkResults("badwrap", 32'h0, 16'd0, 1'b0, 1'b0, 1'b1);
    checkDoneDrop("badwrap", dc0, ac0, 0);

    $display("[TB] bad config burst 3");
    dc0 = done_count; ac0 = ar_count;
    applyStimulus(32'h0000_3000, 32'h10, 8'd3, 3'd2, 2'd3, 16'd3, 1'b0);
    checkOutput("badtype_done_now", 64'(done), 64'(1));
    checkOutput("badtype_err_cfg", 64'(err_cfg), 64'(1));
    checkDoneDrop("badtype", dc0, ac0, 0);

    $display("[TB] legal wrap len 3");
    dc0 = done_count; ac0 = ar_count;
    applyStimulus(32'h0000_0100, 32'h40, 8'd3, 3'd2, 2'd2, 16'd1, 1'b1);
    waitDone(200);
    checkResults("wrap", sumBursts(32'h0000_0100, 32'h40, 4, 1), 16'd4, 1'b0, 1'b0, 1'b0);
    checkDoneDrop("wrap", dc0, ac0, 1);

    $display("[TB] address wrap and SLVERR");
    resp_err = 1'b1;
    dc0 = done_count; ac0 = ar_count;
    applyStimulus(32'hFFFF_FFF0, 32'h20, 8'd3, 3'd2, 2'd1, 16'd2, 1'b1);
    waitDone(200);
    checkResults("slverr", sumBursts(32'hFFFF_FFF0, 32'h20, 4, 2), 16'd8, 1'b1, 1'b0, 1'b0);
    checkDoneDrop("slverr", dc0, ac0, 2);
    resp_err = 1'b0;

    $display("[TB] reset mid-DATA");
    applyStimulus(32'h8000_0000, 32'h10, 8'd3, 3'd2, 2'd1, 16'd4, 1'b1);
    i = 0;
    while (!m_rready && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    checkOutput("mid_reached_data", 64'(m_rready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    exp_addr_q.delete();
    @(posedge clk); #1;
    checkOutput("mid_busy", 64'(busy), 64'(0));
    checkOutput("mid_arvalid", 64'(m_arvalid), 64'(0));
    checkOutput("mid_rready", 64'(m_rready), 64'(0));
    checkOutput("mid_araddr", 64'(m_araddr), 64'(0));
    checkResults("mid", 32'h0, 16'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    dc0 = done_count; ac0 = ar_count;
    applyStimulus(32'h8000_0000, 32'h10, 8'd3, 3'd2, 2'd1, 16'd4, 1'b1);
    waitDone(200);
    checkResults("post", sumBursts(32'h8000_0000, 32'h10, 4, 4), 16'd16, 1'b0, 1'b0, 1'b0);
    checkDoneDrop("post", dc0, ac0, 4);

    $display("[TB] zero bursts");
    dc0 = done_count; ac0 = ar_count;
    applyStimulus(32'h0000_4000, 32'h10, 8'd3, 3'd2, 2'd1, 16'd0, 1'b1);
    checkOutput("zero_done_now", 64'(done), 64'(1));
    checkOutput("zero_arvalid", 64'(m_arvalid), 64'(0));
    checkResults("zero", 32'h0, 16'd0, 1'b0, 1'b0, 1'b0);
    checkDoneDrop("zero", dc0, ac0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
